// File: rtl/vec_alu_sequencer.sv
// One-command-at-a-time sequencer for the 16-lane vector ALU: read two RF sources, register operands, execute, write lo/hi.
// Handshake cycle N -> low write N+4, high write + done N+5; cmd_ready held low until back in IDLE (no queueing).
module vec_alu_sequencer #(
    parameter int W      = 512,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [REG_AW-1:0] cmd_src_a,
    input  logic [REG_AW-1:0] cmd_src_b,
    input  logic [REG_AW-1:0] cmd_dst,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [W-1:0]      rf_rdata_a,
    input  logic [W-1:0]      rf_rdata_b,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [W-1:0]      rf_wdata,
    output logic [W-1:0]      alu_a1,
    output logic [W-1:0]      alu_a2,
    output logic              alu_op,
    input  logic [W-1:0]      alu_a3,
    input  logic [W-1:0]      alu_a4,
    output logic              busy,
    output logic              done,
    output logic [15:0]       op_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_OPND, S_EXEC, S_WB_LO, S_WB_HI
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_op;
    logic [REG_AW-1:0] r_src_a;
    logic [REG_AW-1:0] r_src_b;
    logic [REG_AW-1:0] r_dst;
    logic [W-1:0]      r_alu_a1;
    logic [W-1:0]      r_alu_a2;
    logic              r_alu_op;
    logic [W-1:0]      r_res_lo;
    logic [W-1:0]      r_res_hi;
    logic [15:0]       r_op_count;
    logic [REG_AW-1:0] w_dst_hi;

    // High half lands in the next register, wrapping past the top of the file.
    assign w_dst_hi = r_dst + REG_AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_next = S_READ;
            end
            S_READ: begin
                rf_raddr_a = r_src_a;
                rf_raddr_b = r_src_b;
                w_next     = S_OPND;
            end
            S_OPND: begin
                rf_raddr_a = r_src_a;
                rf_raddr_b = r_src_b;
                w_next     = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_WB_LO;
            end
            S_WB_LO: begin
                rf_we    = 1'b1;
                rf_waddr = r_dst;
                rf_wdata = r_res_lo;
                w_next   = S_WB_HI;
            end
            S_WB_HI: begin
                rf_we    = 1'b1;
                rf_waddr = w_dst_hi;
                rf_wdata = r_res_hi;
                done     = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= 1'b0;
            r_src_a    <= '0;
            r_src_b    <= '0;
            r_dst      <= '0;
            r_alu_a1   <= '0;
            r_alu_a2   <= '0;
            r_alu_op   <= 1'b0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_op_count <= '0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_op    <= cmd_op;
                r_src_a <= cmd_src_a;
                r_src_b <= cmd_src_b;
                r_dst   <= cmd_dst;
            end
            // Operands are captured once per command so the ALU inputs stay stable through EXEC.
            if (r_state == S_OPND) begin
                r_alu_a1 <= rf_rdata_a;
                r_alu_a2 <= rf_rdata_b;
                r_alu_op <= r_op;
            end
            if (r_state == S_EXEC) begin
                r_res_lo <= alu_a3;
                r_res_hi <= alu_a4;
            end
            if (r_state == S_WB_HI) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign alu_a1   = r_alu_a1;
    assign alu_a2   = r_alu_a2;
    assign alu_op   = r_alu_op;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Scoreboard bench: directed commands push hand-computed RF writes; a negedge monitor pops and compares every write.
module tb_vec_alu_sequencer;
    localparam int W  = 512;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_src_a;
    logic [AW-1:0] cmd_src_b;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] rf_raddr_a;
    logic [AW-1:0] rf_raddr_b;
    logic [W-1:0]  rf_rdata_a;
    logic [W-1:0]  rf_rdata_b;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  alu_a1;
    logic [W-1:0]  alu_a2;
    logic          alu_op;
    logic [W-1:0]  alu_a3;
    logic [W-1:0]  alu_a4;
    logic          busy;
    logic          done;
    logic [15:0]   op_count;

    always #5 clk = ~clk;

    vec_alu_sequencer #(.W(W), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_op(alu_op),
        .alu_a3(alu_a3), .alu_a4(alu_a4),
        .busy(busy), .done(done), .op_count(op_count)
    );

    // Signed 32x32 lanes: add gives sign-extended sum, multiply gives full 64-bit product.
    function automatic logic [2*W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic [2*W-1:0]     r;
        logic signed [63:0] sa, sb, p;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            sa = {{32{a[32*i+31]}}, a[32*i +: 32]};
            sb = {{32{b[32*i+31]}}, b[32*i +: 32]};
            p  = op ? sa * sb : sa + sb;
            r[32*i +: 32]     = p[31:0];
            r[W+32*i +: 32]   = p[63:32];
        end
        return r;
    endfunction

    assign {alu_a4, alu_a3} = alu_f(alu_a1, alu_a2, alu_op);

    logic [W-1:0]  mem [4];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        rf_rdata_a <= mem[rf_raddr_a];
        rf_rdata_b <= mem[rf_raddr_b];
        if (rf_we)  mem[rf_waddr] <= rf_wdata;
        if (ld_en)  mem[ld_addr]  <= ld_data;
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [31:0] x);
        return {16{x}};
    endfunction

    always @(negedge clk) begin
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0h, no write expected", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", W'(rf_waddr), W'(mon_e.a));
                chk("wr_data", rf_wdata, mon_e.d);
            end
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                         input logic [AW-1:0] dst, output int hs);
        bit got;
        got = 1'b0;
        hs  = 0;
        cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst;
        cmd_valid = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                hs  = cyc;
            end
        end
        if (!got) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        bit got;
        got = 1'b0;
        dc  = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                dc  = cyc;
            end
        end
        if (!got) chk("done_timeout", 1, 0);
        @(negedge clk);
        chk("done_one_cycle", W'(done), 0);
    endtask

    logic [W-1:0] mul_a, mul_b, mul_lo, mul_hi;
    int           hs, dc;
    int           hsb [3];
    bit           got;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        ld_addr = '0; ld_data = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_cmd_ready", W'(cmd_ready), 1);
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_rf_we", W'(rf_we), 0);
        chk("rst_op_count", W'(op_count), 0);
        chk("rst_alu_a1", alu_a1, '0);
        chk("rst_alu_op", W'(alu_op), 0);

        preload(0, rep(32'd5));
        preload(1, rep(32'd7));
        preload(2, rep(32'hDEAD));
        preload(3, rep(32'hBEEF));
        @(posedge clk); #1 rst = 1'b0;

        // Basic add.
        push(2, rep(32'd12));
        push(3, rep(32'd0));
        issue(1'b0, 0, 1, 2, hs);
        wait_done(dc);
        chk("add_latency", W'(dc - hs), 5);
        chk("add_op_count", W'(op_count), 1);

        // Sign word of an add.
        preload(0, rep(32'hFFFF_FFFF));
        preload(3, rep(32'd0));
        push(1, rep(32'hFFFF_FFFF));
        push(2, rep(32'hFFFF_FFFF));
        issue(1'b0, 0, 3, 1, hs);
        wait_done(dc);
        chk("sadd_op_count", W'(op_count), 2);

        // Multiply: lane 0 is -3 x 4, other lanes 2^16 x 2^16.
        mul_a = rep(32'h0001_0000); mul_a[31:0] = 32'hFFFF_FFFD;
        mul_b = rep(32'h0001_0000); mul_b[31:0] = 32'd4;
        mul_lo = rep(32'd0);        mul_lo[31:0] = 32'hFFFF_FFF4;
        mul_hi = rep(32'd1);        mul_hi[31:0] = 32'hFFFF_FFFF;
        preload(2, mul_a);
        preload(3, mul_b);
        push(0, mul_lo);
        push(1, mul_hi);
        issue(1'b1, 2, 3, 0, hs);
        wait_done(dc);
        chk("mul_latency", W'(dc - hs), 5);
        chk("mul_op_count", W'(op_count), 3);

        // dst=3 wraps high half to reg 0; both sources alias the destination.
        preload(3, rep(32'd2));
        preload(0, rep(32'd9));
        push(3, rep(32'd4));
        push(0, rep(32'd0));
        issue(1'b0, 3, 3, 3, hs);
        wait_done(dc);
        chk("wrap_op_count", W'(op_count), 4);

        // Back-to-back with cmd_valid held high.
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rst2_op_count", W'(op_count), 0);
        preload(0, rep(32'd1));
        preload(1, rep(32'd2));
        preload(2, rep(32'd3));
        preload(3, rep(32'd0));
        @(posedge clk); #1 rst = 1'b0;
        push(2, rep(32'd3));  push(3, rep(32'd0));
        push(0, rep(32'd6));  push(1, rep(32'd0));
        push(1, rep(32'd18)); push(2, rep(32'd0));
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin cmd_op = 1'b0; cmd_src_a = 0; cmd_src_b = 1; cmd_dst = 2; end
                1: begin cmd_op = 1'b0; cmd_src_a = 2; cmd_src_b = 2; cmd_dst = 0; end
                default: begin cmd_op = 1'b1; cmd_src_a = 0; cmd_src_b = 2; cmd_dst = 1; end
            endcase
            got    = 1'b0;
            hsb[k] = 0;
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk);
                if (cmd_ready) begin
                    got    = 1'b1;
                    hsb[k] = cyc;
                end else begin
                    chk("b2b_busy_not_ready", W'({busy, cmd_ready}), W'(2'b10));
                end
            end
            if (!got) chk("b2b_accept_timeout", 1, 0);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("b2b_spacing_1", W'(hsb[1] - hsb[0]), 6);
        chk("b2b_spacing_2", W'(hsb[2] - hsb[1]), 6);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_op_count", W'(op_count), 3);
        chk("b2b_idle", W'({busy, cmd_ready}), W'(2'b01));

        // Reset in WB_LO: nothing gets written, outputs drop immediately.
        preload(0, rep(32'd1));
        preload(1, rep(32'd1));
        preload(2, rep(32'hAAAA));
        preload(3, rep(32'hBBBB));
        issue(1'b0, 0, 1, 2, hs);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rf_we", W'(rf_we), 0);
        chk("midrst_busy", W'(busy), 0);
        chk("midrst_ready", W'(cmd_ready), 1);
        chk("midrst_done", W'(done), 0);
        chk("midrst_op_count", W'(op_count), 0);
        chk("midrst_alu_a1", alu_a1, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_reg2_kept", mem[2], rep(32'hAAAA));
        chk("midrst_reg3_kept", mem[3], rep(32'hBBBB));
        push(2, rep(32'd2));
        push(3, rep(32'd0));
        issue(1'b0, 0, 1, 2, hs);
        wait_done(dc);
        chk("postrst_latency", W'(dc - hs), 5);
        @(posedge clk); #1;
        chk("postrst_op_count", W'(op_count), 1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", W'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
Control FSM that sequences one vector arithmetic command at a time through the shared 16-lane x 32-bit vector ALU (add/multiply, 512-bit A1/A2 in, A3 low / A4 high out). It accepts a command over a valid/ready handshake and reads two source vector registers from the register file. It drives the ALU from registered operands, then writes the low result to the destination register and the high result to the next register. It sits between instruction decode and the vector register file.

Parameters:
W, 512, vector width in bits (16 lanes x 32); fixed, ALU is not parameterised
REG_AW, 2, register-file address width (4 vector registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_op  in  1  0 = add, 1 = multiply
cmd_src_a  in  REG_AW  source register A
cmd_src_b  in  REG_AW  source register B
cmd_dst  in  REG_AW  destination register (low half); high half goes to cmd_dst+1
rf_raddr_a  out  REG_AW  RF read address A
rf_raddr_b  out  REG_AW  RF read address B
rf_rdata_a  in  W  RF read data A, valid one cycle after address
rf_rdata_b  in  W  RF read data B, valid one cycle after address
rf_we  out  1  RF write enable
rf_waddr  out  REG_AW  RF write address
rf_wdata  out  W  RF write data
alu_a1  out  W  ALU operand 1 (registered)
alu_a2  out  W  ALU operand 2 (registered)
alu_op  out  1  ALU operation select
alu_a3  in  W  ALU low result (combinational from alu_a1/alu_a2/alu_op)
alu_a4  in  W  ALU high result / sign word
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, command retired
op_count  out  16  number of retired commands

Behaviour:
- States: IDLE, READ, OPND, EXEC, WB_LO, WB_HI. Moore outputs are decoded from state and latched fields.
- IDLE: cmd_ready=1. If cmd_valid, latch op/src_a/src_b/dst and go to READ; otherwise stay in IDLE.
- READ: rf_raddr_a/b = latched sources. Go to OPND.
- OPND: rf_raddr held. Register alu_a1<=rf_rdata_a, alu_a2<=rf_rdata_b, alu_op<=latched op. Go to EXEC.
- EXEC: alu_a1/a2/op stable. Latch res_lo<=alu_a3, res_hi<=alu_a4. Go to WB_LO.
- WB_LO: rf_we=1, rf_waddr=dst, rf_wdata=res_lo. Go to WB_HI.
- WB_HI: rf_we=1, rf_waddr=(dst+1) mod 2^REG_AW (dst=3 writes reg 0), rf_wdata=res_hi, done=1, op_count+=1 (wraps 65535->0). Go to IDLE.
- Latency: handshake cycle N; low write at N+4; high write and done at N+5; next accept no earlier than N+6.
- cmd_ready=0 in all non-IDLE states. cmd inputs are ignored outside IDLE; commands are never queued.
- Sources are read before any write, so src equal to dst or dst+1 uses pre-command values.
- alu_a1/alu_a2/alu_op change only in OPND and hold until the next OPND.
- rf_we=0 outside WB_LO/WB_HI. rf_waddr/rf_wdata are 0 when rf_we=0.
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, rf_we=0, all addresses/data/operands/results/op_count=0, alu_op=0.
- Reset mid-operation: immediate return to IDLE. No further RF write occurs; a pending WB_HI does not happen. op_count is cleared.

Test Plan:
- Add: reg0 all lanes 5, reg1 all lanes 7, cmd add src_a=0 src_b=1 dst=2 -> reg2 lanes 12, reg3 all 0; done exactly 5 cycles after handshake; op_count=1.
- Signed add: lane 0xFFFFFFFF + 0x00000000, dst=1 -> reg1 lane 0xFFFFFFFF, reg2 lane 0xFFFFFFFF (sign word).
- Multiply: lanes 0x00010000 x 0x00010000, dst=0 -> reg0 lanes 0x00000000, reg1 lanes 0x00000001; lane -3 x 4 -> low 0xFFFFFFF4, high 0xFFFFFFFF.
- Wrap and aliasing: src_a=3 src_b=3 dst=3 add, reg3 lanes 2 -> reg3 lanes 4, reg0 lanes 0; operands read before overwrite.
- Back-to-back: cmd_valid held high with 3 commands -> accepts spaced exactly 6 cycles, cmd_ready low while busy, op_count=3, no dropped or duplicated writes.
- Reset asserted in WB_LO -> no WB_HI write, outputs at reset values asynchronously; next command after release completes normally with op_count=1.
